// File: rtl/w25q64_cmd_ctrl.sv
// W25Q64 command sequencer: expands single-cycle user requests into WREN / command / RDSR-poll SPI frame chains.
// Latency: frame start one cycle after accept or after CS gap; backpressure: issue stalls while the driver is busy, requests only taken when o_ready.
module w25q64_cmd_ctrl #(
    parameter int          CS_GAP   = 4,
    parameter logic [15:0] POLL_MAX = 16'd50000
) (
    input  logic        i_sys_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic [1:0]  i_op,
    input  logic [23:0] i_addr,
    input  logic [7:0]  i_wdata,
    output logic        o_ready,
    output logic        o_done,
    output logic        o_err,
    output logic [23:0] o_rdata,
    output logic        o_spi_en,
    output logic [5:0]  o_spi_len,
    output logic [39:0] o_spi_tx_data,
    input  logic        i_spi_busy,
    input  logic        i_spi_done,
    input  logic [39:0] i_spi_rx_data
);

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_PROG  = 2'd1;
    localparam logic [1:0] OP_ERASE = 2'd2;
    localparam logic [1:0] OP_JEDEC = 2'd3;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_PROG  = 8'h02;
    localparam logic [7:0] CMD_ERASE = 8'h20;
    localparam logic [7:0] CMD_JEDEC = 8'h9F;
    localparam logic [7:0] CMD_WREN  = 8'h06;
    localparam logic [7:0] CMD_RDSR  = 8'h05;

    localparam logic [15:0] GAP_LAST = (CS_GAP > 1) ? 16'(CS_GAP - 1) : 16'd0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WREN_ISSUE,
        ST_WREN_WAIT,
        ST_CMD_ISSUE,
        ST_CMD_WAIT,
        ST_POLL_ISSUE,
        ST_POLL_WAIT,
        ST_GAP,
        ST_FINISH
    } state_t;

    state_t      state;
    state_t      gap_next;
    logic [1:0]  op;
    logic [23:0] addr;
    logic [7:0]  wdata;
    logic [15:0] poll_cnt;
    logic [15:0] gap_cnt;
    logic        err_pend;

    logic [39:0] cmd_frame;
    logic [5:0]  cmd_len;
    logic        write_op;
    logic        frame_done;
    logic        unused_rx;

    // A done coinciding with our own start pulse belongs to an older frame.
    assign frame_done = i_spi_done && !o_spi_en;
    assign write_op   = (op == OP_PROG) || (op == OP_ERASE);
    assign unused_rx  = ^i_spi_rx_data[39:24];

    always_comb begin
        cmd_frame = {CMD_READ, addr, 8'h00};
        cmd_len   = 6'd40;
        case (op)
            OP_PROG: begin
                cmd_frame = {CMD_PROG, addr, wdata};
                cmd_len   = 6'd40;
            end
            OP_ERASE: begin
                cmd_frame = {CMD_ERASE, addr, 8'h00};
                cmd_len   = 6'd32;
            end
            OP_JEDEC: begin
                cmd_frame = {CMD_JEDEC, 32'h0};
                cmd_len   = 6'd32;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            state         <= ST_IDLE;
            gap_next      <= ST_IDLE;
            op            <= OP_READ;
            addr          <= 24'h0;
            wdata         <= 8'h0;
            poll_cnt      <= 16'h0;
            gap_cnt       <= 16'h0;
            err_pend      <= 1'b0;
            o_ready       <= 1'b1;
            o_done        <= 1'b0;
            o_err         <= 1'b0;
            o_rdata       <= 24'h0;
            o_spi_en      <= 1'b0;
            o_spi_len     <= 6'd0;
            o_spi_tx_data <= 40'h0;
        end else begin
            o_spi_en <= 1'b0;
            o_done   <= 1'b0;
            o_err    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (o_ready && i_req) begin
                        op       <= i_op;
                        addr     <= i_addr;
                        wdata    <= i_wdata;
                        poll_cnt <= 16'h0;
                        err_pend <= 1'b0;
                        o_ready  <= 1'b0;
                        state    <= ((i_op == OP_PROG) || (i_op == OP_ERASE)) ? ST_WREN_ISSUE
                                                                              : ST_CMD_ISSUE;
                    end else begin
                        o_ready <= 1'b1;
                    end
                end
                ST_WREN_ISSUE: begin
                    if (!i_spi_busy) begin
                        o_spi_en      <= 1'b1;
                        o_spi_tx_data <= {CMD_WREN, 32'h0};
                        o_spi_len     <= 6'd8;
                        state         <= ST_WREN_WAIT;
                    end
                end
                ST_WREN_WAIT: begin
                    if (frame_done) begin
                        gap_cnt  <= 16'h0;
                        gap_next <= ST_CMD_ISSUE;
                        state    <= ST_GAP;
                    end
                end
                ST_CMD_ISSUE: begin
                    if (!i_spi_busy) begin
                        o_spi_en      <= 1'b1;
                        o_spi_tx_data <= cmd_frame;
                        o_spi_len     <= cmd_len;
                        state         <= ST_CMD_WAIT;
                    end
                end
                ST_CMD_WAIT: begin
                    if (frame_done) begin
                        if (write_op) begin
                            gap_cnt  <= 16'h0;
                            gap_next <= ST_POLL_ISSUE;
                            state    <= ST_GAP;
                        end else begin
                            o_rdata <= (op == OP_JEDEC) ? i_spi_rx_data[23:0]
                                                        : {16'h0, i_spi_rx_data[7:0]};
                            state   <= ST_FINISH;
                        end
                    end
                end
                ST_POLL_ISSUE: begin
                    if (!i_spi_busy) begin
                        o_spi_en      <= 1'b1;
                        o_spi_tx_data <= {CMD_RDSR, 32'h0};
                        o_spi_len     <= 6'd16;
                        poll_cnt      <= poll_cnt + 16'd1;
                        state         <= ST_POLL_WAIT;
                    end
                end
                ST_POLL_WAIT: begin
                    if (frame_done) begin
                        if (!i_spi_rx_data[0]) begin
                            state <= ST_FINISH;
                        end else if (poll_cnt < POLL_MAX) begin
                            gap_cnt  <= 16'h0;
                            gap_next <= ST_POLL_ISSUE;
                            state    <= ST_GAP;
                        end else begin
                            err_pend <= 1'b1;
                            state    <= ST_FINISH;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt >= GAP_LAST) begin
                        state <= gap_next;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                ST_FINISH: begin
                    o_done <= 1'b1;
                    o_err  <= err_pend;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    a_spi_en_single: assert property (@(posedge i_sys_clk) disable iff (i_reset)
        o_spi_en |=> !o_spi_en);

endmodule

// File: tb/tb_w25q64_cmd_ctrl.sv
// Bench for w25q64_cmd_ctrl: SPI driver model, table vectors, corner sequences and random ops vs a frame-list model.
module tb_w25q64_cmd_ctrl;

    localparam int CS_GAP   = 4;
    localparam int POLL_MAX = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [1:0]  op;
    logic [23:0] addr;
    logic [7:0]  wdata;
    logic        ready, done, err;
    logic [23:0] rdata;
    logic        spi_en;
    logic [5:0]  spi_len;
    logic [39:0] spi_tx;
    logic        spi_busy, spi_done;
    logic [39:0] spi_rx;

    logic        drv_busy = 1'b0, force_busy = 1'b0, drv_done = 1'b0, stray_done = 1'b0;
    logic [39:0] drv_rx = 40'h0;
    assign spi_busy = drv_busy | force_busy;
    assign spi_done = drv_done | stray_done;
    assign spi_rx   = drv_rx;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    w25q64_cmd_ctrl #(.CS_GAP(CS_GAP), .POLL_MAX(16'(POLL_MAX))) dut (
        .i_sys_clk(clk), .i_reset(reset), .i_req(req), .i_op(op), .i_addr(addr),
        .i_wdata(wdata), .o_ready(ready), .o_done(done), .o_err(err), .o_rdata(rdata),
        .o_spi_en(spi_en), .o_spi_len(spi_len), .o_spi_tx_data(spi_tx),
        .i_spi_busy(spi_busy), .i_spi_done(spi_done), .i_spi_rx_data(spi_rx)
    );

    typedef struct packed {
        logic [5:0]  len;
        logic [39:0] dat;
    } frame_t;

    typedef struct {
        logic [1:0]  op;
        logic [23:0] addr;
        logic [7:0]  wdata;
        logic [39:0] rx;
        int          bp;
        logic [23:0] exp_rdata;
        logic        exp_err;
        int          exp_n;
    } vec_t;

    frame_t      act_q[$];
    frame_t      exp_q[$];
    int          checks = 0, errors = 0;
    int          poll_idx = 0, busy_polls = 0;
    int          lat_min = 1, lat_max = 5;
    int          last_done_cyc = 0, first_en_cyc = 0;
    logic [39:0] rx_word = 40'h0;
    logic        inject_stray = 1'b0;
    logic [23:0] model_rdata = 24'h0;
    logic        model_err = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    // Expected frame list and result, straight from the command set.
    task automatic model_op(input logic [1:0] m_op, input logic [23:0] m_addr,
                            input logic [7:0] m_wd, input logic [39:0] m_rx, input int m_bp);
        int n;
        exp_q.delete();
        model_err = 1'b0;
        case (m_op)
            2'd0: begin
                exp_q.push_back({6'd40, 8'h03, m_addr, 8'h00});
                model_rdata = {16'h0, m_rx[7:0]};
            end
            2'd3: begin
                exp_q.push_back({6'd32, 8'h9F, 32'h0});
                model_rdata = m_rx[23:0];
            end
            default: begin
                exp_q.push_back({6'd8, 8'h06, 32'h0});
                if (m_op == 2'd1) exp_q.push_back({6'd40, 8'h02, m_addr, m_wd});
                else              exp_q.push_back({6'd32, 8'h20, m_addr, 8'h00});
                n = (m_bp < POLL_MAX) ? m_bp + 1 : POLL_MAX;
                model_err = (m_bp >= POLL_MAX);
                for (int k = 0; k < n; k++) exp_q.push_back({6'd16, 8'h05, 32'h0});
            end
        endcase
    endtask

    // SPI driver model: logs frames, holds busy for a random time, then pulses done.
    initial begin
        int     lat;
        frame_t f;
        logic [7:0] status;
        forever begin
            @(negedge clk);
            drv_done = 1'b0;
            drv_rx   = 40'h0;
            if (spi_en) begin
                f = {spi_len, spi_tx};
                if (act_q.size() > 0) check("frame_gap", 64'(cyc - last_done_cyc), 64'(CS_GAP + 2));
                else first_en_cyc = cyc;
                act_q.push_back(f);
                if (inject_stray) begin
                    stray_done   = 1'b1;
                    inject_stray = 1'b0;
                end
                drv_busy = 1'b1;
                lat = $urandom_range(lat_max, lat_min);
                @(negedge clk);
                stray_done = 1'b0;
                check("en_single", 64'(spi_en), 64'(0));
                repeat (lat - 1) @(negedge clk);
                if (f.dat[39:32] == 8'h05) begin
                    status    = 8'($urandom);
                    status[0] = (poll_idx < busy_polls);
                    poll_idx++;
                    drv_rx = {32'($urandom), status};
                end else begin
                    drv_rx = rx_word;
                end
                drv_busy      = 1'b0;
                drv_done      = 1'b1;
                last_done_cyc = cyc;
            end
        end
    end

    task automatic run_op(input logic [1:0] t_op, input logic [23:0] t_addr, input logic [7:0] t_wd,
                          input logic [39:0] t_rx, input int t_bp, input int hold, input string nm,
                          output logic [23:0] got_rdata, output logic got_err, output int got_n);
        int   t;
        int   req_cyc;
        logic ready_bad, en_seen;
        got_rdata = 24'h0; got_err = 1'b0; got_n = 0;
        t = 0;
        while (!ready && t < 200) begin @(negedge clk); t++; end
        check({nm, "_ready_wait"}, 64'(ready), 64'(1));
        act_q.delete();
        poll_idx = 0; busy_polls = t_bp; rx_word = t_rx;
        model_op(t_op, t_addr, t_wd, t_rx, t_bp);
        if (hold > 0) force_busy = 1'b1;
        req = 1'b1; op = t_op; addr = t_addr; wdata = t_wd; req_cyc = cyc;
        @(negedge clk);
        req = 1'b0; op = 2'($urandom); addr = 24'($urandom); wdata = 8'($urandom);
        check({nm, "_ready_drop"}, 64'(ready), 64'(0));
        if (hold > 0) begin
            en_seen = 1'b0;
            for (int k = 0; k < hold; k++) begin
                if (spi_en) en_seen = 1'b1;
                req = (k == 3);
                if (k == 3) op = 2'd3;
                @(negedge clk);
            end
            req = 1'b0;
            force_busy = 1'b0;
            check({nm, "_en_held_off"}, 64'(en_seen), 64'(0));
            @(negedge clk);
            check({nm, "_en_after_busy"}, 64'(spi_en), 64'(1));
        end
        ready_bad = 1'b0;
        t = 0;
        while (done !== 1'b1 && t < 1000) begin
            if (ready) ready_bad = 1'b1;
            @(negedge clk);
            t++;
        end
        if (done !== 1'b1) begin
            checks++; errors++;
            $display("FAIL %s_done_timeout: no o_done within %0d cycles", nm, t);
            return;
        end
        got_rdata = rdata; got_err = err;
        check({nm, "_done_lat"}, 64'(cyc - last_done_cyc), 64'(2));
        check({nm, "_ready_low"}, 64'(ready_bad), 64'(0));
        if (hold == 0) check({nm, "_first_en_lat"}, 64'(first_en_cyc - req_cyc), 64'(2));
        @(negedge clk);
        check({nm, "_ready_back"}, 64'({ready, done}), 64'(2'b10));
        got_n = act_q.size();
        check({nm, "_nframes"}, 64'(act_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_frame%0d", nm, i), 64'(act_q[i]), 64'(exp_q[i]));
        check({nm, "_rdata"}, 64'(got_rdata), 64'(model_rdata));
        check({nm, "_err"}, 64'(got_err), 64'(model_err));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[7];
        logic [23:0] g_rd;
        logic        g_err, flag;
        int          g_n, n0, t;

        vecs[0] = '{2'd0, 24'h000123, 8'h00, 40'h12345678A5, 0,    24'h0000A5, 1'b0, 1};
        vecs[1] = '{2'd3, 24'h000000, 8'h00, 40'hABCDEF4017, 0,    24'hEF4017, 1'b0, 1};
        vecs[2] = '{2'd1, 24'h000010, 8'h3C, 40'h0000000000, 3,    24'hEF4017, 1'b0, 6};
        vecs[3] = '{2'd2, 24'h123000, 8'h00, 40'h0000000000, 1000, 24'hEF4017, 1'b1, 7};
        vecs[4] = '{2'd1, 24'hFFFFFF, 8'hA5, 40'h0000000000, 0,    24'hEF4017, 1'b0, 3};
        vecs[5] = '{2'd2, 24'h800000, 8'h00, 40'h0000000000, 4,    24'hEF4017, 1'b0, 7};
        vecs[6] = '{2'd0, 24'hFFFFFE, 8'h00, 40'h99887766FF, 0,    24'h0000FF, 1'b0, 1};

        reset = 1'b1; req = 1'b0; op = 2'd0; addr = 24'h0; wdata = 8'h0;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(ready), 64'(1));
        check("rst_done_err_en", 64'({done, err, spi_en}), 64'(0));
        check("rst_rdata", 64'(rdata), 64'(0));
        check("rst_len_tx", 64'({spi_len, spi_tx}), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].rx, vecs[i].bp, 0,
                   $sformatf("vec%0d", i), g_rd, g_err, g_n);
            check($sformatf("vec%0d_tab_rdata", i), 64'(g_rd), 64'(vecs[i].exp_rdata));
            check($sformatf("vec%0d_tab_err", i), 64'(g_err), 64'(vecs[i].exp_err));
            check($sformatf("vec%0d_tab_n", i), 64'(g_n), 64'(vecs[i].exp_n));
        end

        // Driver busy for 10 cycles at issue, with a stray request mid-operation.
        run_op(2'd0, 24'h0ABCDE, 8'h00, 40'h00000000C3, 0, 10, "busyhold", g_rd, g_err, g_n);
        n0 = act_q.size(); flag = 1'b0;
        repeat (20) begin
            if (done || !ready) flag = 1'b1;
            @(negedge clk);
        end
        check("stray_req_frames", 64'(act_q.size()), 64'(n0));
        check("stray_req_idle", 64'(flag), 64'(0));

        // A done pulse in the same cycle as the start pulse must not end the frame.
        inject_stray = 1'b1;
        run_op(2'd0, 24'h00BEEF, 8'h00, 40'h000000005A, 0, 0, "stray_done", g_rd, g_err, g_n);

        // Reset during the poll phase of a PROGRAM.
        lat_min = 4; lat_max = 6;
        act_q.delete(); poll_idx = 0; busy_polls = 1000;
        req = 1'b1; op = 2'd1; addr = 24'h000200; wdata = 8'h77;
        @(negedge clk);
        req = 1'b0;
        t = 0;
        while (act_q.size() < 3 && t < 500) begin @(negedge clk); t++; end
        check("rst_mid_reach_poll", 64'(act_q.size() >= 3), 64'(1));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_rdata = 24'h0;
        check("rst_mid_ready", 64'(ready), 64'(1));
        check("rst_mid_done_err_en", 64'({done, err, spi_en}), 64'(0));
        check("rst_mid_rdata", 64'(rdata), 64'(0));
        check("rst_mid_len_tx", 64'({spi_len, spi_tx}), 64'(0));
        n0 = act_q.size(); flag = 1'b0;
        repeat (30) begin
            if (done || spi_en) flag = 1'b1;
            @(negedge clk);
        end
        check("rst_mid_late_done_ignored", 64'(flag), 64'(0));
        check("rst_mid_no_frames", 64'(act_q.size()), 64'(n0));
        lat_min = 1; lat_max = 5;

        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom), 24'($urandom), 8'($urandom), {8'($urandom), 32'($urandom)},
                   $urandom_range(6, 0), 0, $sformatf("rnd%0d", i), g_rd, g_err, g_n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
